pbs_battle_dp: RTL and testbench
================================

// Module: pbs_battle_dp
// PURPOSE
//  Parametrised battle datapath for the PBS turn engine. It is the successor to the fixed 4-bit player/AI HP datapath.
//  - Owns both HP registers and an internal LFSR random source.
//  - Sequences one attack per start pulse: select move, roll accuracy, apply saturating damage, report.
//  - Adds behaviour the old datapath lacked: accuracy gating, KO detection, game-over lockout, new-game reload.
//  - Sits between the turn-control FSM and the HP display logic.
// PARAMETERS
//  HP_W     4       HP register width; MAX_HP = 2**HP_W-1
//  MOVE_W   2       move index width; N_MOVES = 2**MOVE_W
//  ACC_W    4       accuracy / roll width
//  SEED     16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  start      in   1       attack request; sampled only in IDLE
//  attacker   in   1       0 = player attacks AI, 1 = AI attacks player
//  p_move     in   MOVE_W  player move index; used when attacker=0
//  new_game   in   1       reload both HPs to MAX_HP; honoured only in IDLE
//  busy       out  1       high from SELECT through DONE
//  done       out  1       one-cycle pulse in DONE
//  hit        out  1       result of the last attack; held until the next ROLL
//  dmg        out  HP_W    damage applied by the last attack (0 on miss); held
//  p_hp       out  HP_W    player HP
//  ai_hp      out  HP_W    AI HP
//  game_over  out  1       (p_hp==0) | (ai_hp==0)
// BEHAVIOUR
//  Reset
//   - State = IDLE; p_hp = ai_hp = MAX_HP; hit = 0; dmg = 0; busy = 0; done = 0; LFSR = SEED.
//   - Reset mid-attack aborts the attack and takes precedence over every other input.
//  LFSR
//   - 16-bit Galois LFSR, taps 16'hB400, shifts every cycle after reset.
//   - Bits [MOVE_W-1:0] give the AI move; bits [15:16-ACC_W] give the accuracy roll.
//  FSM states and transitions
//   - IDLE -> SELECT when start=1 and game_over=0.
//   - SELECT: latch the attacker; latch move = attacker ? lfsr[MOVE_W-1:0] : p_move; look up dmg_t and acc_t in the move table.
//   - ROLL: roll = lfsr upper ACC_W bits; hit_q = (roll <= acc_t). An accuracy of all-ones always hits.
//   - APPLY: apply damage to the target, which is the AI when attacker=0, else the player.
//     - tgt <= (dmg_t >= tgt) ? 0 : tgt - dmg_t (saturates at 0).
//     - On a miss, no HP changes and dmg <= 0.
//   - DONE: done=1 for exactly one cycle; next state is IDLE.
//  Latency
//   - start accepted in cycle T -> HP visible in cycle T+4, together with done=1.
//   - busy is high for cycles T+1..T+4.
//   - Earliest next accept is cycle T+5.
//  Boundary conditions
//   - start while busy: ignored, not queued.
//   - start while game_over=1: ignored; busy and done stay low.
//   - new_game and start together in IDLE: new_game wins and start is dropped. HP = MAX_HP from the next cycle.
//   - new_game while busy: ignored.
//   - Damage to a target already at 0 HP cannot occur, because of the game_over lockout.
//   - Only one HP register is written per attack.
//  Width rules
//   - Move-table damage is HP_W bits; accuracy is ACC_W bits.
//   - All compares are unsigned; there is no wrap-around.
// STRUCTURE
//  - Package pbs_pkg holds:
//    - the state enum (IDLE, SELECT, ROLL, APPLY, DONE);
//    - LFSR_TAPS;
//    - functions move_dmg(idx) and move_acc(idx), where the table entry repeats at idx mod 4:
//      - idx 0 -> dmg 3, acc 15
//      - idx 1 -> dmg 5, acc 11
//      - idx 2 -> dmg 8, acc 5
//      - idx 3 -> dmg 1, acc 15
//  - Sub-module pbs_lfsr (clk, rst, SEED) -> lfsr[15:0].
//  - FSM and HP registers stay in this module.
// TESTING
//  - Reset: rst=1 for 2 cycles -> p_hp=ai_hp=15, busy=0, done=0, hit=0, dmg=0.
//  - Sure hit: attacker=0, p_move=0, start in cycle T -> done at T+4, hit=1, dmg=3, ai_hp=12, p_hp=15.
//  - Saturation: preload ai_hp=3 with p_move=3 attacks, then p_move=2 with a forced hit.
//    -> ai_hp=0, dmg=8, game_over=1; a further start gives busy=0 and no done pulse.
//  - Miss: SEED chosen so that roll > 5 on p_move=2 -> hit=0, dmg=0, both HPs unchanged, done pulse still issued.
//  - Overlap and reload:
//    - start pulsed at T+2 of an attack -> exactly one done.
//    - new_game with start in IDLE -> HPs = 15, no busy.
//  - Mid-attack reset: rst=1 in APPLY -> no HP write, state IDLE; the next start completes normally.
//  - AI turn: attacker=1, 1000 random turns against a reference model using the same LFSR.
//    -> p_hp, hit and dmg match every turn.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared types, constants and move table for the PBS battle datapath.
// The move table repeats every four entries, so wider move indices alias onto it.
package pbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ROLL   = 3'd2,
    ST_APPLY  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] move_dmg(input logic [1:0] idx);
    case (idx)
      2'd0: return 8'd3;
      2'd1: return 8'd5;
      2'd2: return 8'd8;
      2'd3: return 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] move_acc(input logic [1:0] idx);
    case (idx)
      2'd0: return 8'd15;
      2'd1: return 8'd11;
      2'd2: return 8'd5;
      2'd3: return 8'd15;
    endcase
  endfunction

endpackage

// File: rtl/pbs_lfsr.sv
// 16-bit Galois LFSR random source; free-running from SEED after reset.
module pbs_lfsr
  import pbs_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/pbs_battle_dp.sv
// PBS battle datapath: one attack per start pulse (select, roll, apply, done),
// owning both HP registers, with a game-over lockout and new-game reload.
module pbs_battle_dp
  import pbs_pkg::*;
#(
  parameter int          HP_W   = 4,
  parameter int          MOVE_W = 2,
  parameter int          ACC_W  = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              attacker,
  input  logic [MOVE_W-1:0] p_move,
  input  logic              new_game,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [HP_W-1:0]   dmg,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   ai_hp,
  output logic              game_over
);

  localparam logic [HP_W-1:0] MAX_HP = '1;

  state_t            state_reg, state_next;
  logic              atk_reg;
  logic [HP_W-1:0]   dmg_t_reg;
  logic [ACC_W-1:0]  acc_t_reg;
  logic              hit_reg;
  logic [HP_W-1:0]   dmg_reg;
  logic [HP_W-1:0]   p_hp_reg;
  logic [HP_W-1:0]   ai_hp_reg;

  logic [15:0]       lfsr;
  logic              unused_lfsr;
  logic [MOVE_W-1:0] sel_move;
  logic [HP_W-1:0]   sel_dmg;
  logic [ACC_W-1:0]  sel_acc;
  logic [ACC_W-1:0]  roll;
  logic [HP_W-1:0]   tgt_hp;
  logic [HP_W-1:0]   tgt_next;
  logic              over;

  pbs_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only a few LFSR bits feed the datapath; the rest are intentionally dropped.
  assign unused_lfsr = ^lfsr;

  assign sel_move = attacker ? lfsr[MOVE_W-1:0] : p_move;
  assign sel_dmg  = HP_W'(move_dmg(2'(sel_move)));
  assign sel_acc  = ACC_W'(move_acc(2'(sel_move)));
  assign roll     = lfsr[15 -: ACC_W];

  assign tgt_hp   = atk_reg ? p_hp_reg : ai_hp_reg;
  assign tgt_next = (dmg_t_reg >= tgt_hp) ? '0 : tgt_hp - dmg_t_reg;

  assign over     = (p_hp_reg == '0) | (ai_hp_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // new_game has priority over start in IDLE
      ST_IDLE:   if (!new_game && start && !over) state_next = ST_SELECT;
      ST_SELECT: state_next = ST_ROLL;
      ST_ROLL:   state_next = ST_APPLY;
      ST_APPLY:  state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      atk_reg   <= 1'b0;
      dmg_t_reg <= '0;
      acc_t_reg <= '0;
      hit_reg   <= 1'b0;
      dmg_reg   <= '0;
      p_hp_reg  <= MAX_HP;
      ai_hp_reg <= MAX_HP;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (new_game) begin
            p_hp_reg  <= MAX_HP;
            ai_hp_reg <= MAX_HP;
          end
        end
        ST_SELECT: begin
          atk_reg   <= attacker;
          dmg_t_reg <= sel_dmg;
          acc_t_reg <= sel_acc;
        end
        ST_ROLL: begin
          hit_reg <= (roll <= acc_t_reg);
        end
        ST_APPLY: begin
          if (hit_reg) begin
            dmg_reg <= dmg_t_reg;
            if (atk_reg) p_hp_reg <= tgt_next;
            else         ai_hp_reg <= tgt_next;
          end else begin
            dmg_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign hit       = hit_reg;
  assign dmg       = dmg_reg;
  assign p_hp      = p_hp_reg;
  assign ai_hp     = ai_hp_reg;
  assign game_over = over;

endmodule

// File: tb/tb_pbs_battle_dp.sv
// Directed and model-driven checks for pbs_battle_dp (default parameters).
module tb_pbs_battle_dp;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       attacker;
  logic [1:0] p_move;
  logic       new_game;
  logic       busy;
  logic       done;
  logic       hit;
  logic [3:0] dmg;
  logic [3:0] p_hp;
  logic [3:0] ai_hp;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  m_p_hp, m_ai_hp, m_dmg;
  logic        m_hit;

  pbs_battle_dp #(
    .HP_W   (4),
    .MOVE_W (2),
    .ACC_W  (4),
    .SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .attacker  (attacker),
    .p_move    (p_move),
    .new_game  (new_game),
    .busy      (busy),
    .done      (done),
    .hit       (hit),
    .dmg       (dmg),
    .p_hp      (p_hp),
    .ai_hp     (ai_hp),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference copy of the random source, stepped in lockstep with the DUT.
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [3:0] tbl_dmg(input logic [1:0] i);
    case (i)
      2'd0: return 4'd3;
      2'd1: return 4'd5;
      2'd2: return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] tbl_acc(input logic [1:0] i);
    case (i)
      2'd0: return 4'd15;
      2'd1: return 4'd11;
      2'd2: return 4'd5;
      default: return 4'd15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait in IDLE until a start issued now would roll a hit (want=1) or a miss (want=0).
  task automatic wait_roll(input logic want, input logic [3:0] acc, input string tag);
    logic [15:0] l2;
    logic        found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      l2 = lfsr_step(lfsr_step(m_lfsr));
      if ((l2[15:12] <= acc) == want) found = 1'b1;
      else tick();
    end
    check({tag, " roll alignment"}, 32'(found), 1);
  endtask

  // Issue one attack in the current (IDLE) cycle T and check it through T+5.
  task automatic do_attack(input logic att, input logic [1:0] mv, input string tag);
    logic [15:0] l1, l2;
    logic [1:0]  mvx;
    logic [3:0]  d;
    logic        h;
    l1  = lfsr_step(m_lfsr);
    l2  = lfsr_step(l1);
    mvx = att ? l1[1:0] : mv;
    d   = tbl_dmg(mvx);
    h   = (l2[15:12] <= tbl_acc(mvx));
    attacker = att;
    p_move   = mv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy@T+1"}, 32'(busy), 1);
    check({tag, " done@T+1"}, 32'(done), 0);
    tick();
    tick();
    check({tag, " done@T+3"}, 32'(done), 0);
    tick();
    m_hit = h;
    m_dmg = h ? d : 4'd0;
    if (h) begin
      if (att) m_p_hp  = (d >= m_p_hp)  ? 4'd0 : m_p_hp - d;
      else     m_ai_hp = (d >= m_ai_hp) ? 4'd0 : m_ai_hp - d;
    end
    check({tag, " done@T+4"}, 32'(done), 1);
    check({tag, " busy@T+4"}, 32'(busy), 1);
    check({tag, " hit"}, 32'(hit), 32'(m_hit));
    check({tag, " dmg"}, 32'(dmg), 32'(m_dmg));
    check({tag, " p_hp"}, 32'(p_hp), 32'(m_p_hp));
    check({tag, " ai_hp"}, 32'(ai_hp), 32'(m_ai_hp));
    check({tag, " game_over"}, 32'(game_over), 32'((m_p_hp == 0) || (m_ai_hp == 0)));
    $display("atk %s att=%0d move=%0d hit=%0d dmg=%0d p_hp=%0d ai_hp=%0d",
             tag, att, mvx, hit, dmg, p_hp, ai_hp);
    tick();
    check({tag, " done@T+5"}, 32'(done), 0);
    check({tag, " busy@T+5"}, 32'(busy), 0);
  endtask

  initial begin
    int n_done;
    rst      = 1'b1;
    start    = 1'b0;
    attacker = 1'b0;
    p_move   = 2'd0;
    new_game = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_p_hp = 4'd15; m_ai_hp = 4'd15; m_hit = 1'b0; m_dmg = 4'd0;
    check("reset p_hp", 32'(p_hp), 15);
    check("reset ai_hp", 32'(ai_hp), 15);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset hit", 32'(hit), 0);
    check("reset dmg", 32'(dmg), 0);
    check("reset game_over", 32'(game_over), 0);
    $display("reset p_hp=%0d ai_hp=%0d", p_hp, ai_hp);

    // Sure hit
    do_attack(1'b0, 2'd0, "sure_hit");
    check("sure_hit hit", 32'(hit), 1);
    check("sure_hit dmg", 32'(dmg), 3);
    check("sure_hit ai_hp", 32'(ai_hp), 12);
    check("sure_hit p_hp", 32'(p_hp), 15);

    // Saturation: chip AI down to 3, then a forced 8-damage hit
    for (int i = 0; i < 9; i++) do_attack(1'b0, 2'd3, "chip");
    check("chip ai_hp", 32'(ai_hp), 3);
    wait_roll(1'b1, 4'd5, "sat");
    do_attack(1'b0, 2'd2, "sat");
    check("sat ai_hp", 32'(ai_hp), 0);
    check("sat dmg", 32'(dmg), 8);
    check("sat game_over", 32'(game_over), 1);

    // Start during game over is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("locked busy", 32'(busy), 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      tick();
    end
    check("locked done count", 32'(n_done), 0);
    check("locked ai_hp", 32'(ai_hp), 0);
    $display("locked start ignored, done pulses=%0d", n_done);

    // new_game together with start: reload wins, no attack
    new_game = 1'b1;
    start    = 1'b1;
    tick();
    new_game = 1'b0;
    start    = 1'b0;
    m_p_hp = 4'd15; m_ai_hp = 4'd15;
    check("reload busy", 32'(busy), 0);
    check("reload p_hp", 32'(p_hp), 15);
    check("reload ai_hp", 32'(ai_hp), 15);
    check("reload game_over", 32'(game_over), 0);
    tick();
    check("reload busy+1", 32'(busy), 0);
    $display("new_game+start p_hp=%0d ai_hp=%0d busy=%0d", p_hp, ai_hp, busy);

    // Miss
    wait_roll(1'b0, 4'd5, "miss");
    do_attack(1'b0, 2'd2, "miss");
    check("miss hit", 32'(hit), 0);
    check("miss dmg", 32'(dmg), 0);
    check("miss ai_hp", 32'(ai_hp), 15);
    check("miss p_hp", 32'(p_hp), 15);

    // Overlapping start and new_game while busy are ignored
    attacker = 1'b0;
    p_move   = 2'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start    = 1'b1;
    new_game = 1'b1;
    tick();
    start    = 1'b0;
    new_game = 1'b0;
    n_done   = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      tick();
    end
    m_ai_hp = 4'd14; m_hit = 1'b1; m_dmg = 4'd1;
    check("overlap done count", 32'(n_done), 1);
    check("overlap ai_hp", 32'(ai_hp), 14);
    check("overlap busy", 32'(busy), 0);
    $display("overlap done pulses=%0d ai_hp=%0d", n_done, ai_hp);

    // Reset during APPLY
    attacker = 1'b0;
    p_move   = 2'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_p_hp = 4'd15; m_ai_hp = 4'd15; m_hit = 1'b0; m_dmg = 4'd0;
    check("midrst busy", 32'(busy), 0);
    check("midrst done", 32'(done), 0);
    check("midrst ai_hp", 32'(ai_hp), 15);
    check("midrst p_hp", 32'(p_hp), 15);
    check("midrst dmg", 32'(dmg), 0);
    $display("mid-attack reset ai_hp=%0d busy=%0d", ai_hp, busy);
    do_attack(1'b0, 2'd0, "post_rst");
    check("post_rst ai_hp", 32'(ai_hp), 12);

    // AI turns against the reference model
    for (int t = 0; t < 1000; t++) begin
      if ((m_p_hp == 0) || (m_ai_hp == 0)) begin
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        m_p_hp = 4'd15; m_ai_hp = 4'd15;
        check("ai reload p_hp", 32'(p_hp), 15);
      end
      repeat ($urandom_range(0, 3)) tick();
      do_attack(1'b1, 2'($urandom), "ai_turn");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
